hms_seg_src: RTL and testbench

HMS_SEG_SRC -- requirements
Module: hms_seg_src

---
 rtl/hms_seg_src_pkg.sv | 74 +++++++
 rtl/hms_seg_src_nco.sv | 41 ++++
 rtl/hms_seg_src.sv | 102 ++++++++++
 tb/tb_hms_seg_src.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hms_seg_src_pkg.sv
// Shared constants, types and helpers for the hh:mm:ss seven-segment source.
//   - 7-segment codes ({a,b,c,d,e,f,g}, 1 = lit) for digits 0-9
//   - field-select encodings for set mode
//   - field limits and widths, packed time-of-day struct
package hms_seg_src_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned N_DIGITS  = 6;
    localparam int unsigned SEG_BUS_W = SEG_W * N_DIGITS;
    localparam int unsigned DP_W      = N_DIGITS;
    localparam int unsigned SEC_W     = 6;
    localparam int unsigned MIN_W     = 6;
    localparam int unsigned HOUR_W    = 5;
    localparam int unsigned POS_W     = 2;

    localparam logic [POS_W-1:0] SEL_SEC  = 2'd0;
    localparam logic [POS_W-1:0] SEL_MIN  = 2'd1;
    localparam logic [POS_W-1:0] SEL_HOUR = 2'd2;
    localparam logic [POS_W-1:0] SEL_NONE = 2'd3;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } hms_t;

    // Modulo-60 increment shared by seconds and minutes.
    function automatic logic [SEC_W-1:0] inc_mod60(input logic [SEC_W-1:0] v);
        return (v == SEC_MAX) ? SEC_W'(0) : v + SEC_W'(1);
    endfunction

    // Modulo-24 increment for hours.
    function automatic logic [HOUR_W-1:0] inc_mod24(input logic [HOUR_W-1:0] v);
        return (v == HOUR_MAX) ? HOUR_W'(0) : v + HOUR_W'(1);
    endfunction

    // One decimal digit to its segment code; out-of-range digits go blank.
    function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_W'(0);
        endcase
    endfunction

    // Split a 0-59 field into {tens code, ones code}.
    function automatic logic [2*SEG_W-1:0] seg_field(input logic [5:0] v);
        return {seg_digit(4'(v / 6'd10)), seg_digit(4'(v % 6'd10))};
    endfunction

endpackage

// File: rtl/hms_seg_src_nco.sv
// Divide-by-N tick generator.
//   clk, rst     : clock, async active-high reset
//   i_nco_num    : cycles per tick; 0 stops the counter at 0 with no ticks
//   o_tick       : registered one-cycle pulse as the counter wraps
module nco #(
    parameter int unsigned NCO_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCO_W-1:0] i_nco_num,
    output logic             o_tick
);

    logic [NCO_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Wrap at num-1; ">=" also recovers if num shrinks below the current count.
    always_comb begin
        cnt_d  = cnt_q + NCO_W'(1);
        tick_d = 1'b0;
        if (i_nco_num == '0) begin
            cnt_d = '0;
        end else if (cnt_q >= i_nco_num - NCO_W'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/hms_seg_src.sv
// hh:mm:ss clock driving six seven-segment digits with decimal points.
//   clk, rst         : clock, async active-high reset
//   i_nco_num        : clk cycles per one-second tick (0 = stopped)
//   i_mode           : 0 = run, 1 = set
//   i_position       : field edited in set mode (sec/min/hour/none)
//   i_inc            : one-cycle increment request, honoured in set mode only
//   o_six_digit_seg  : {hour tens, hour ones, min tens, min ones, sec tens, sec ones}
//   o_six_dp         : decimal points, same digit order
//   o_tick           : one-cycle pulse per NCO period
module hms_seg_src
    import hms_seg_src_pkg::*;
#(
    parameter int unsigned NCO_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCO_W-1:0]     i_nco_num,
    input  logic                 i_mode,
    input  logic [1:0]           i_position,
    input  logic                 i_inc,
    output logic [41:0]          o_six_digit_seg,
    output logic [5:0]           o_six_dp,
    output logic                 o_tick
);

    logic [NCO_W-1:0]     nco_num_eff;
    logic                 tick;
    hms_t                 time_q, time_d;
    logic                 blink_q, blink_d;
    logic [SEG_BUS_W-1:0] seg_q, seg_d;
    logic [DP_W-1:0]      dp_q, dp_d;

    // Set mode presents a zero divide value, which parks the counter at 0.
    assign nco_num_eff = i_mode ? '0 : i_nco_num;

    nco #(.NCO_W(NCO_W)) u_nco (
        .clk       (clk),
        .rst       (rst),
        .i_nco_num (nco_num_eff),
        .o_tick    (tick)
    );

    // Time update: a pending tick always wins, so a tick that lands on the
    // run->set transition is still counted.
    always_comb begin
        time_d  = time_q;
        blink_d = blink_q;
        if (tick) begin
            blink_d     = ~blink_q;
            time_d.sec  = inc_mod60(time_q.sec);
            if (time_q.sec == SEC_MAX) begin
                time_d.min = inc_mod60(time_q.min);
                if (time_q.min == MIN_MAX) begin
                    time_d.hour = inc_mod24(time_q.hour);
                end
            end
        end else if (i_mode && i_inc) begin
            case (i_position)
                SEL_SEC:  time_d.sec  = inc_mod60(time_q.sec);
                SEL_MIN:  time_d.min  = inc_mod60(time_q.min);
                SEL_HOUR: time_d.hour = inc_mod24(time_q.hour);
                default:  ;
            endcase
        end
    end

    // Display encode and decimal-point select.
    always_comb begin
        seg_d = {seg_field({1'b0, time_q.hour}), seg_field(time_q.min), seg_field(time_q.sec)};
        dp_d  = '0;
        if (i_mode) begin
            case (i_position)
                SEL_SEC:  dp_d[0] = 1'b1;
                SEL_MIN:  dp_d[2] = 1'b1;
                SEL_HOUR: dp_d[4] = 1'b1;
                default:  ;
            endcase
        end else begin
            dp_d[2] = blink_q;
            dp_d[4] = blink_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q  <= '0;
            blink_q <= 1'b0;
            seg_q   <= {N_DIGITS{SEG_0}};
            dp_q    <= '0;
        end else begin
            time_q  <= time_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign o_six_digit_seg = seg_q;
    assign o_six_dp        = dp_q;
    assign o_tick          = tick;

endmodule

// File: tb/tb_hms_seg_src.sv
// Bench for hms_seg_src: directed table of set-mode edits, hand-written
// corner sequences, and a randomized run against a time-of-day reference.
module tb_hms_seg_src;

    logic        clk;
    logic        rst;
    logic [31:0] i_nco_num;
    logic        i_mode;
    logic [1:0]  i_position;
    logic        i_inc;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic        o_tick;

    hms_seg_src #(.NCO_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_nco_num       (i_nco_num),
        .i_mode          (i_mode),
        .i_position      (i_position),
        .i_inc           (i_inc),
        .o_six_digit_seg (o_six_digit_seg),
        .o_six_dp        (o_six_dp),
        .o_tick          (o_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference state: time of day, blink, divider phase, expected outputs.
    int          m_h, m_m, m_s;
    bit          m_blink;
    logic [31:0] m_cnt;
    bit          m_tick;
    logic [41:0] e_seg;
    logic [5:0]  e_dp;

    typedef struct {
        logic [1:0] pos;
        int         n;
        int         h;
        int         m;
        int         s;
        logic [5:0] dp;
    } row_t;

    row_t rows[$];

    function automatic logic [6:0] digit7(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [41:0] enc_time(input int h, input int m, input int s);
        return {digit7(h / 10), digit7(h % 10), digit7(m / 10), digit7(m % 10),
                digit7(s / 10), digit7(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0;
        m_blink = 1'b0;
        m_cnt = 32'd0;
        m_tick = 1'b0;
        e_seg = enc_time(0, 0, 0);
        e_dp = 6'b000000;
    endtask

    // One clock edge of the reference, using the inputs sampled at that edge.
    task automatic model_edge();
        int total;
        if (rst) begin
            model_reset();
            return;
        end
        e_seg = enc_time(m_h, m_m, m_s);
        if (i_mode)
            e_dp = (i_position == 2'd0) ? 6'b000001 :
                   (i_position == 2'd1) ? 6'b000100 :
                   (i_position == 2'd2) ? 6'b010000 : 6'b000000;
        else
            e_dp = {1'b0, m_blink, 1'b0, m_blink, 2'b00};
        if (m_tick) begin
            total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = total / 3600;
            m_m = (total / 60) % 60;
            m_s = total % 60;
            m_blink = !m_blink;
        end else if (i_mode && i_inc) begin
            case (i_position)
                2'd0: m_s = (m_s + 1) % 60;
                2'd1: m_m = (m_m + 1) % 60;
                2'd2: m_h = (m_h + 1) % 24;
                default: ;
            endcase
        end
        if (i_mode || i_nco_num == 32'd0) begin
            m_cnt = 32'd0;
            m_tick = 1'b0;
        end else if (m_cnt == i_nco_num - 32'd1) begin
            m_cnt = 32'd0;
            m_tick = 1'b1;
        end else begin
            m_cnt = m_cnt + 32'd1;
            m_tick = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tick", 64'(o_tick), 64'(m_tick));
        chk("seg", 64'(o_six_digit_seg), 64'(e_seg));
        chk("dp", 64'(o_six_dp), 64'(e_dp));
    endtask

    task automatic wait_tick(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (o_tick) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic set_field(input logic [1:0] pos, input int n);
        i_position = pos;
        i_inc = 1'b1;
        repeat (n) cycle();
        i_inc = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] zeros_lit;
        logic [41:0] req_1234_lit;
        int          ticks;

        zeros_lit    = {6{7'b1111110}};
        req_1234_lit = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111};
        vectors = 0;
        miscompares = 0;

        rows.push_back('{2'd2, 12, 12,  0,  0, 6'b010000});
        rows.push_back('{2'd1, 34, 12, 34,  0, 6'b000100});
        rows.push_back('{2'd0, 56, 12, 34, 56, 6'b000001});
        rows.push_back('{2'd3,  5, 12, 34, 56, 6'b000000});
        rows.push_back('{2'd2, 11, 23, 34, 56, 6'b010000});
        rows.push_back('{2'd2,  1,  0, 34, 56, 6'b010000});
        rows.push_back('{2'd1, 25,  0, 59, 56, 6'b000100});
        rows.push_back('{2'd1,  1,  0,  0, 56, 6'b000100});
        rows.push_back('{2'd0,  3,  0,  0, 59, 6'b000001});
        rows.push_back('{2'd0,  1,  0,  0,  0, 6'b000001});
        rows.push_back('{2'd2, 23, 23,  0,  0, 6'b010000});
        rows.push_back('{2'd1, 59, 23, 59,  0, 6'b000100});
        rows.push_back('{2'd0, 59, 23, 59, 59, 6'b000001});

        rst = 1'b1; i_mode = 1'b0; i_position = 2'd0; i_inc = 1'b0; i_nco_num = 32'd5;
        model_reset();
        repeat (2) cycle();
        chk("reset_seg", 64'(o_six_digit_seg), 64'(zeros_lit));
        chk("reset_dp", 64'(o_six_dp), 64'd0);

        // Tick period 5 from reset release.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            chk("tick_period", 64'(o_tick), 64'(k % 5 == 0));
        end

        // Set-mode edits from 00:00:00.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        i_mode = 1'b1;
        foreach (rows[r]) begin
            set_field(rows[r].pos, rows[r].n);
            chk("row_seg", 64'(o_six_digit_seg), 64'(enc_time(rows[r].h, rows[r].m, rows[r].s)));
            chk("row_dp", 64'(o_six_dp), 64'(rows[r].dp));
            if (rows[r].h == 12 && rows[r].m == 34 && rows[r].s == 56 && rows[r].pos == 2'd0)
                chk("seg_123456", 64'(o_six_digit_seg), 64'(req_1234_lit));
        end

        // 23:59:59 rolls over to midnight on the next tick.
        i_mode = 1'b0;
        i_position = 2'd3;
        i_nco_num = 32'd5;
        wait_tick(20, "wait_midnight_tick");
        cycle();
        cycle();
        chk("midnight_seg", 64'(o_six_digit_seg), 64'(zeros_lit));
        chk("midnight_dp", 64'(o_six_dp), 64'b010100);

        // i_inc ignored in run mode; no ticks with a zero divide value.
        i_position = 2'(($urandom_range(0, 2)));
        i_inc = 1'b1;
        cycle();
        i_inc = 1'b0;
        repeat (3) cycle();
        i_nco_num = 32'd0;
        ticks = 0;
        for (int k = 0; k < 1000; k++) begin
            cycle();
            if (o_tick) ticks++;
        end
        chk("no_tick_num0", 64'(ticks), 64'd0);

        // Entering set mode in the same cycle as a tick.
        i_nco_num = 32'd3;
        wait_tick(10, "wait_mode_tick");
        i_mode = 1'b1;
        repeat (4) cycle();
        chk("set_tick_low", 64'(o_tick), 64'd0);

        // Asynchronous reset mid-count at 12:34:56.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        i_mode = 1'b1;
        set_field(2'd2, 12);
        set_field(2'd1, 34);
        set_field(2'd0, 56);
        i_mode = 1'b0;
        i_nco_num = 32'd7;
        repeat (3) cycle();
        chk("pre_rst_seg", 64'(o_six_digit_seg), 64'(req_1234_lit));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_seg", 64'(o_six_digit_seg), 64'(zeros_lit));
        chk("async_rst_dp", 64'(o_six_dp), 64'd0);
        chk("async_rst_tick", 64'(o_tick), 64'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            chk("resume_tick", 64'(o_tick), 64'(k == 7));
        end

        // Randomized run; divide value only changes while the counter is parked.
        i_mode = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) i_mode = ~i_mode;
            if (i_mode && $urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 5))
                    0: i_nco_num = 32'd0;
                    1: i_nco_num = 32'd1;
                    2: i_nco_num = 32'd2;
                    3: i_nco_num = 32'd3;
                    4: i_nco_num = 32'd5;
                    default: i_nco_num = 32'd7;
                endcase
            end
            i_position = 2'($urandom_range(0, 3));
            i_inc = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        i_inc = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
